// File: rtl/modn_event_pkg.sv
// ----------------------------------------------------------------------------
// modn_event_pkg
//   Shared definitions for the modulo-N event counter.
//   - MODE_WRAP / MODE_SAT : values for the SATURATE parameter
//   - count_max(width)     : largest count value representable in 'width' bits
//   Optional feature macro used by this block: MODN_EVENT_IRQ_EN
// ----------------------------------------------------------------------------
package modn_event_pkg;

  localparam int MODE_WRAP = 0;  // count wraps 2**WIDTH-1 -> 0
  localparam int MODE_SAT  = 1;  // count holds at 2**WIDTH-1

  // Valid for width < 32.
  function automatic logic [31:0] count_max(input int width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/modn_event_counter_if.sv
// ----------------------------------------------------------------------------
// modn_event_counter_if
//   Groups the event/divisor/status signals of modn_event_counter.
//   master : event source + status consumer (drives ain_i, div_i, div_load_i,
//            irq_clr_i; observes hit_o, count_o, ovf_o, irq_o)
//   slave  : the counter itself
//   count_o packs channel 0 in the least significant WIDTH bits.
// ----------------------------------------------------------------------------
interface modn_event_counter_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 8
);
  logic [NCH-1:0]       ain_i;
  logic [WIDTH-1:0]     div_i;
  logic                 div_load_i;
  logic [NCH-1:0]       irq_clr_i;
  logic [NCH-1:0]       hit_o;
  logic [NCH*WIDTH-1:0] count_o;
  logic [NCH-1:0]       ovf_o;
  logic [NCH-1:0]       irq_o;

  modport master (
    output ain_i, div_i, div_load_i, irq_clr_i,
    input  hit_o, count_o, ovf_o, irq_o
  );

  modport slave (
    input  ain_i, div_i, div_load_i, irq_clr_i,
    output hit_o, count_o, ovf_o, irq_o
  );
endinterface

// File: rtl/modn_event_chan.sv
// ----------------------------------------------------------------------------
// modn_event_chan
//   One counter channel: modulo-div_q residue, event count, sticky overflow,
//   optional sticky irq, and the combinational (Mealy) hit output.
//   Ports:
//     clk, reset   clock, synchronous active-high reset
//     ain          event strobe (one event per high cycle)
//     div_load     clears residue/count/ovf, drops this cycle's event
//     div_q        current divisor (0 disables the detector)
//     irq_clr      clears irq (a coincident hit wins)
//     hit          event completes a multiple of div_q (combinational)
//     count        registered event count
//     ovf          sticky wrap/saturation flag
//     irq          sticky hit flag; tied 0 unless MODN_EVENT_IRQ_EN is defined
// ----------------------------------------------------------------------------
module modn_event_chan
  import modn_event_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ain,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_q,
  input  logic             irq_clr,
  output logic             hit,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             irq
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(count_max(WIDTH));

  logic [WIDTH-1:0] residue;
  logic             det_en;
  logic             last;

  // NOTE: purely combinational with every term fully specified, so no latch
  // can be inferred; hit is the Mealy output and is deliberately not a flop.
  assign det_en = (div_q != '0);
  assign last   = (residue == div_q - WIDTH'(1));
  assign hit    = ain & ~reset & ~div_load & det_en & last;

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || div_load) begin
      residue <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else if (ain) begin
      // Residue keeps tracking even when the count is saturated.
      residue <= (!det_en || last) ? '0 : residue + WIDTH'(1);
      if (count == CNT_MAX) begin
        ovf <= 1'b1;
        if (SATURATE == MODE_SAT) count <= CNT_MAX;
        else                      count <= '0;
      end else begin
        count <= count + WIDTH'(1);
      end
    end
  end

`ifdef MODN_EVENT_IRQ_EN
  // Load does not touch irq; a new hit beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset)        irq <= 1'b0;
    else if (hit)     irq <= 1'b1;
    else if (irq_clr) irq <= 1'b0;
  end
`else
  logic irq_clr_unused;
  assign irq_clr_unused = irq_clr;
  assign irq            = 1'b0;
`endif

endmodule

// File: rtl/modn_event_counter.sv
// ----------------------------------------------------------------------------
// modn_event_counter
//   Multi-channel event counter with a runtime-programmable modulo-N Mealy
//   detector. Holds the shared divisor register and instantiates one
//   modn_event_chan per channel.
//   Ports:
//     clk    clock, all state on rising edge
//     reset  synchronous, active-high; has priority over div_load_i
//     bus    modn_event_counter_if.slave:
//              ain_i, div_i, div_load_i, irq_clr_i (in)
//              hit_o, count_o (ch0 in LSBs), ovf_o, irq_o (out)
//   Optional feature macro: MODN_EVENT_IRQ_EN (sticky irq_o per channel).
// ----------------------------------------------------------------------------
module modn_event_counter
  import modn_event_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int WIDTH       = 8,
  parameter int DIV_DEFAULT = 3,
  parameter int SATURATE    = MODE_WRAP
) (
  input  logic              clk,
  input  logic              reset,
  modn_event_counter_if.slave bus
);

  logic [WIDTH-1:0]     div_q;
  logic [NCH-1:0]       hit;
  logic [NCH-1:0]       ovf;
  logic [NCH-1:0]       irq;
  logic [NCH*WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)               div_q <= WIDTH'(DIV_DEFAULT);
    else if (bus.div_load_i) div_q <= bus.div_i;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    modn_event_chan #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .ain      (bus.ain_i[g]),
      .div_load (bus.div_load_i),
      .div_q    (div_q),
      .irq_clr  (bus.irq_clr_i[g]),
      .hit      (hit[g]),
      .count    (count[g*WIDTH +: WIDTH]),
      .ovf      (ovf[g]),
      .irq      (irq[g])
    );
  end

  assign bus.hit_o   = hit;
  assign bus.count_o = count;
  assign bus.ovf_o   = ovf;
  assign bus.irq_o   = irq;

endmodule

// File: tb/tb_modn_event_counter.sv
// ----------------------------------------------------------------------------
// tb_modn_event_counter
//   Three counters share one stimulus stream:
//     a: WIDTH=8 wrap, b: WIDTH=4 wrap, c: WIDTH=4 saturate (all NCH=4, DIV_DEFAULT=3).
//   The reference model keeps the total number of events per channel since
//   reset/load and derives count, residue, overflow and hit from that total
//   with plain arithmetic. Expected per-cycle outputs go into a queue; a
//   monitor pops and compares on the falling edge.
//   Honours MODN_EVENT_IRQ_EN for the irq expectation.
// ----------------------------------------------------------------------------
module tb_modn_event_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ain;
  logic [3:0] clr;
  logic [7:0] div;
  logic       load;

  always #5 clk = ~clk;

  modn_event_counter_if #(.NCH(4), .WIDTH(8)) if_a ();
  modn_event_counter_if #(.NCH(4), .WIDTH(4)) if_b ();
  modn_event_counter_if #(.NCH(4), .WIDTH(4)) if_c ();

  assign if_a.ain_i = ain;  assign if_a.div_i = div;       assign if_a.div_load_i = load; assign if_a.irq_clr_i = clr;
  assign if_b.ain_i = ain;  assign if_b.div_i = div[3:0];  assign if_b.div_load_i = load; assign if_b.irq_clr_i = clr;
  assign if_c.ain_i = ain;  assign if_c.div_i = div[3:0];  assign if_c.div_load_i = load; assign if_c.irq_clr_i = clr;

  modn_event_counter #(.NCH(4), .WIDTH(8), .DIV_DEFAULT(3), .SATURATE(0)) dut_a (.clk(clk), .reset(rst), .bus(if_a));
  modn_event_counter #(.NCH(4), .WIDTH(4), .DIV_DEFAULT(3), .SATURATE(0)) dut_b (.clk(clk), .reset(rst), .bus(if_b));
  modn_event_counter #(.NCH(4), .WIDTH(4), .DIV_DEFAULT(3), .SATURATE(1)) dut_c (.clk(clk), .reset(rst), .bus(if_c));

  typedef struct packed {
    logic [2:0][3:0]  hit;
    logic [2:0][3:0]  ovf;
    logic [2:0][3:0]  irq;
    logic [2:0][31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  // Reference model state
  int         events[4];
  int         divm[3];
  logic [3:0] irqm[3];

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  function automatic int cmax(input int i);
    return (1 << wid(i)) - 1;
  endfunction

  function automatic int exp_cnt(input int i, input int c);
    if (i == 2) return (events[c] > cmax(i)) ? cmax(i) : events[c];
    return events[c] % (cmax(i) + 1);
  endfunction

  function automatic logic exp_hit(input int i, input int c, input logic [3:0] a,
                                   input logic ld, input logic r);
    if (r || ld || !a[c] || divm[i] == 0) return 1'b0;
    return (events[c] % divm[i]) == divm[i] - 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) events[c] = 0;
    for (int i = 0; i < 3; i++) begin
      divm[i] = 3;
      irqm[i] = '0;
    end
  endtask

  // One clock of stimulus: drive, queue the expected view of this cycle, advance the model.
  task automatic cycle(input logic [3:0] a, input logic ld, input logic [7:0] d,
                       input logic [3:0] cl, input logic r);
    exp_t       e;
    logic [3:0] hv[3];
    @(posedge clk);
    #1;
    ain = a; load = ld; div = d; clr = cl; rst = r;
    e = '0;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 4; c++) begin
        hv[i][c]    = exp_hit(i, c, a, ld, r);
        e.hit[i][c] = hv[i][c];
        e.ovf[i][c] = events[c] > cmax(i);
        e.irq[i][c] = irqm[i][c];
        e.cnt[i]    = e.cnt[i] | (32'(exp_cnt(i, c)) << (c * wid(i)));
      end
    end
    sb.push_back(e);
    if (r) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++) begin
`ifdef MODN_EVENT_IRQ_EN
        irqm[i] = (irqm[i] & ~cl) | hv[i];
`endif
        if (ld) divm[i] = int'(d) & cmax(i);
      end
      for (int c = 0; c < 4; c++) events[c] = ld ? 0 : events[c] + int'(a[c]);
    end
  endtask

  // Monitor: compare every queued expectation against the DUT outputs.
  initial begin
    exp_t e;
    exp_t act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act.hit = {if_c.hit_o, if_b.hit_o, if_a.hit_o};
        act.ovf = {if_c.ovf_o, if_b.ovf_o, if_a.ovf_o};
        act.irq = {if_c.irq_o, if_b.irq_o, if_a.irq_o};
        act.cnt = {32'(if_c.count_o), 32'(if_b.count_o), 32'(if_a.count_o)};
        for (int i = 0; i < 3; i++) begin
          check($sformatf("hit[%0d]", i),   32'(act.hit[i]), 32'(e.hit[i]));
          check($sformatf("count[%0d]", i), act.cnt[i],      e.cnt[i]);
          check($sformatf("ovf[%0d]", i),   32'(act.ovf[i]), 32'(e.ovf[i]));
          check($sformatf("irq[%0d]", i),   32'(act.irq[i]), 32'(e.irq[i]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ain = '0; clr = '0; div = '0; load = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    // Reset held with events present: hit must stay low, state at reset values.
    cycle(4'hF, 1'b0, 8'd0, 4'h0, 1'b1);
    cycle(4'h0, 1'b0, 8'd0, 4'h0, 1'b1);

    // Default divisor 3: ch0 hits on events 3 and 6, count ends at 6.
    repeat (6) cycle(4'h1, 1'b0, 8'd0, 4'h0, 1'b0);
    cycle(4'h0, 1'b0, 8'd0, 4'h0, 1'b0);

    // Load 5 with all events high: events dropped, hit forced low.
    cycle(4'hF, 1'b1, 8'd5, 4'h0, 1'b0);
    repeat (10) cycle(4'h2, 1'b0, 8'd0, 4'h0, 1'b0);
    cycle(4'h0, 1'b0, 8'd0, 4'h0, 1'b0);

    // Long all-channel burst: 4-bit wrap/saturate, then 8-bit wrap.
    repeat (270) cycle(4'hF, 1'b0, 8'd0, 4'h0, 1'b0);
    cycle(4'h0, 1'b0, 8'd0, 4'h0, 1'b0);

    // Divisor 0: detector off, counting continues.
    cycle(4'hF, 1'b1, 8'd0, 4'h0, 1'b0);
    repeat (8) cycle(4'hF, 1'b0, 8'd0, 4'h0, 1'b0);
    // Divisor 1: every event hits.
    cycle(4'h0, 1'b1, 8'd1, 4'h0, 1'b0);
    repeat (5) cycle(4'h5, 1'b0, 8'd0, 4'h0, 1'b0);

    // Irq set/clear ordering with divisor 2 on ch0.
    cycle(4'h0, 1'b1, 8'd2, 4'hF, 1'b0);
    cycle(4'h1, 1'b0, 8'd0, 4'h0, 1'b0);
    cycle(4'h1, 1'b0, 8'd0, 4'h0, 1'b0);  // hit
    cycle(4'h1, 1'b0, 8'd0, 4'h0, 1'b0);
    cycle(4'h1, 1'b0, 8'd0, 4'h1, 1'b0);  // hit with clear: set wins
    cycle(4'h0, 1'b0, 8'd0, 4'h0, 1'b0);
    cycle(4'h0, 1'b0, 8'd0, 4'h1, 1'b0);  // clear alone
    cycle(4'h0, 1'b0, 8'd0, 4'h0, 1'b0);

    // Randomised traffic.
    for (int n = 0; n < 500; n++) begin
      logic [7:0] d;
      logic [3:0] cl;
      d  = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(6));
      cl = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
      cycle(4'($urandom), ($urandom_range(19) == 0), d, cl, ($urandom_range(99) == 0));
    end
    cycle(4'h0, 1'b0, 8'd0, 4'h0, 1'b0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
